// File: rtl/duram_frame_reader.sv
// duram_frame_reader: prefetching read sequencer for a duram frame buffer with inter-frame gap
module duram_frame_reader #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9,
  parameter int IFG_CYCLES = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH:0]   i_commit_ptr,
  output logic [ADDR_WIDTH:0]   o_rd_ptr,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_rden,
  input  logic [DATA_WIDTH-1:0] i_ram_q,
  output logic [31:0]           o_out_data,
  output logic                  o_out_eop,
  output logic [1:0]            o_out_bytes,
  output logic                  o_out_err,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [15:0]           o_frame_cnt
);
  typedef enum logic {RUN, GAP} state_t;
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_fifo [3];
  logic [1:0]            r_count, w_wr_idx;
  logic                  r_inflight, w_push, w_pop, w_eop_hs;
  logic [7:0]            r_gap_cnt, w_gap_nxt;
  logic [15:0]           r_frame_cnt;

  assign o_ram_rden  = (r_rd_ptr != i_commit_ptr) && (({1'b0, r_count} + {2'b0, r_inflight}) < 3'd3);
  assign o_rd_ptr    = r_rd_ptr;
  assign o_ram_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
  assign o_out_valid = (r_state == RUN) && (r_count != 2'd0);
  assign o_out_data  = r_fifo[0][31:0];
  assign o_out_eop   = r_fifo[0][32];
  assign o_out_bytes = r_fifo[0][34:33];
  assign o_out_err   = r_fifo[0][35];
  assign o_frame_cnt = r_frame_cnt;
  assign w_push      = r_inflight;
  assign w_pop       = o_out_valid && i_out_ready;
  assign w_eop_hs    = w_pop && o_out_eop;
  assign w_wr_idx    = r_count - {1'b0, w_pop};

  // Read pointer advances on every issued read; in-flight flag marks next-cycle return
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_rd_ptr   <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, o_ram_rden};
      r_inflight <= o_ram_rden;
    end
  end

  // Prefetch FIFO: shifts toward the head on pop, RAM return lands behind the last live entry
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_fifo[2] <= '0;
      r_count   <= 2'd0;
    end else begin
      if (w_pop) begin
        r_fifo[0] <= r_fifo[1];
        r_fifo[1] <= r_fifo[2];
        r_fifo[2] <= '0;
      end
      if (w_push) r_fifo[w_wr_idx] <= i_ram_q;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // State, gap countdown and frame counter registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= RUN;
      r_gap_cnt   <= 8'd0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      if (w_eop_hs) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Enter the gap on an eop handshake, leave it after exactly IFG_CYCLES cycles
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    if (r_state == GAP) begin
      w_gap_nxt   = r_gap_cnt - 8'd1;
      w_state_nxt = (r_gap_cnt == 8'd1) ? RUN : GAP;
    end else if (w_eop_hs && IFG_CYCLES != 0) begin
      w_state_nxt = GAP;
      w_gap_nxt   = 8'(IFG_CYCLES);
    end
  end
endmodule

// File: tb/tb_duram_frame_reader.sv
// tb_duram_frame_reader: directed bench for the frame reader, gapless and 12-cycle-gap instances
module tb_duram_frame_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  c0, c1, rp0, rp1;
  logic [8:0]  ra0, ra1;
  logic        re0, re1;
  logic [35:0] q0, q1;
  logic [31:0] d0, d1;
  logic        eop0, eop1, er0, er1, v0, v1, rdy0, rdy1;
  logic [1:0]  by0, by1;
  logic [15:0] fc0, fc1;
  logic [35:0] mem [512];
  int          n_cmp = 0;
  int          n_bad = 0;

  duram_frame_reader #(.DATA_WIDTH(36), .ADDR_WIDTH(9), .IFG_CYCLES(0)) u0 (
    .i_clock(clk), .i_reset(rst), .i_commit_ptr(c0), .o_rd_ptr(rp0), .o_ram_addr(ra0),
    .o_ram_rden(re0), .i_ram_q(q0), .o_out_data(d0), .o_out_eop(eop0), .o_out_bytes(by0),
    .o_out_err(er0), .o_out_valid(v0), .i_out_ready(rdy0), .o_frame_cnt(fc0));

  duram_frame_reader #(.DATA_WIDTH(36), .ADDR_WIDTH(9), .IFG_CYCLES(12)) u1 (
    .i_clock(clk), .i_reset(rst), .i_commit_ptr(c1), .o_rd_ptr(rp1), .o_ram_addr(ra1),
    .o_ram_rden(re1), .i_ram_q(q1), .o_out_data(d1), .o_out_eop(eop1), .o_out_bytes(by1),
    .o_out_err(er1), .o_out_valid(v1), .i_out_ready(rdy1), .o_frame_cnt(fc1));

  always @(posedge clk) begin
    if (re0) q0 <= mem[ra0];
    if (re1) q1 <= mem[ra1];
  end

  function automatic logic [35:0] wd(input logic [15:0] tag, input logic [8:0] a,
                                     input logic last, input logic [1:0] b, input logic e);
    return {e, b, last, tag, 7'd0, a};
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input logic [9:0] start, input int n, input logic [15:0] tag, input logic eop);
    logic [8:0] a;
    for (int i = 0; i < n; i++) begin
      a = start[8:0] + 9'(i);
      mem[a] = wd(tag, a, eop && i == n - 1, (eop && i == n - 1) ? 2'd1 : 2'd0, 1'b0);
    end
  endtask

  task automatic drain0(input int n, input logic [9:0] start, input logic [15:0] tag, input logic eop);
    int got;
    logic [8:0] a;
    logic [35:0] exp;
    logic last;
    got = 0;
    rdy0 = 1'b1;
    #1;
    for (int i = 0; i < n + 20 && got < n; i++) begin
      if (v0) begin
        a = start[8:0] + 9'(got);
        last = eop && got == n - 1;
        exp = wd(tag, a, last, last ? 2'd1 : 2'd0, 1'b0);
        n_cmp++;
        if ({er0, by0, eop0, d0} !== exp) begin
          n_bad++;
          $display("FAIL drain_word%0d: got %h expected %h", got, {er0, by0, eop0, d0}, exp);
        end
        got++;
      end
      tick;
    end
    n_cmp++;
    if (got !== n) begin
      n_bad++;
      $display("FAIL drain_count: got %0d expected %0d", got, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; c0 = '0; c1 = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({v0, re0, rp0, fc0} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl0: got v=%b re=%b rp=%0d fc=%0d expected all 0", v0, re0, rp0, fc0);
    end
    n_cmp++;
    if ({er0, by0, eop0, d0} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_fields0: got %h expected 0", {er0, by0, eop0, d0});
    end
    n_cmp++;
    if ({v1, re1, rp1, fc1} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl1: got v=%b re=%b rp=%0d fc=%0d expected all 0", v1, re1, rp1, fc1);
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] hr, hv;
    logic [35:0] exp;
    int idx;
    hr = '0; hv = '0; idx = 0;
    for (int i = 0; i < 3; i++) mem[i] = wd(16'h1111, 9'(i), i == 2, i == 2 ? 2'd2 : 2'd0, 1'b0);
    rdy0 = 1'b1;
    c0 = 10'd3;
    #1;
    for (int i = 0; i < 8; i++) begin
      hr[i] = re0;
      hv[i] = v0;
      if (v0) begin
        exp = wd(16'h1111, 9'(idx), idx == 2, idx == 2 ? 2'd2 : 2'd0, 1'b0);
        n_cmp++;
        if ({er0, by0, eop0, d0} !== exp) begin
          n_bad++;
          $display("FAIL single_word%0d: got %h expected %h", idx, {er0, by0, eop0, d0}, exp);
        end
        idx++;
      end
      tick;
    end
    n_cmp++;
    if (hr !== 8'b0000_0111) begin
      n_bad++;
      $display("FAIL single_rden_pattern: got %b expected 00000111", hr);
    end
    n_cmp++;
    if (hv !== 8'b0001_1100) begin
      n_bad++;
      $display("FAIL single_valid_pattern: got %b expected 00011100", hv);
    end
    n_cmp++;
    if (fc0 !== 16'd1) begin
      n_bad++;
      $display("FAIL single_frame_cnt: got %0d expected 1", fc0);
    end
    n_cmp++;
    if (rp0 !== 10'd3) begin
      n_bad++;
      $display("FAIL single_rd_ptr: got %0d expected 3", rp0);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] pat;
    logic [35:0] exp, prev_word;
    logic prev_stall;
    int idx;
    pat = 16'b1011_0010_1101_0110;
    prev_stall = 1'b0; prev_word = '0; idx = 0;
    for (int i = 0; i < 8; i++)
      mem[3 + i] = wd(16'h2222, 9'(3 + i), i == 7, 2'd0, i == 7);
    c0 = 10'd11;
    for (int i = 0; i < 100 && idx < 8; i++) begin
      rdy0 = pat[i % 16];
      #1;
      if (prev_stall) begin
        n_cmp++;
        if ({v0, er0, by0, eop0, d0} !== {1'b1, prev_word}) begin
          n_bad++;
          $display("FAIL bp_stable: got v=%b %h expected v=1 %h", v0, {er0, by0, eop0, d0}, prev_word);
        end
      end
      n_cmp++;
      if (({1'b0, u0.r_count} + {2'b0, u0.r_inflight}) > 3'd3) begin
        n_bad++;
        $display("FAIL bp_credit: got %0d expected <= 3", u0.r_count + u0.r_inflight);
      end
      if (v0 && rdy0) begin
        exp = wd(16'h2222, 9'(3 + idx), idx == 7, 2'd0, idx == 7);
        n_cmp++;
        if ({er0, by0, eop0, d0} !== exp) begin
          n_bad++;
          $display("FAIL bp_word%0d: got %h expected %h", idx, {er0, by0, eop0, d0}, exp);
        end
        idx++;
      end
      prev_stall = v0 && !rdy0;
      prev_word = {er0, by0, eop0, d0};
      tick;
    end
    n_cmp++;
    if (idx !== 8) begin
      n_bad++;
      $display("FAIL bp_count: got %0d expected 8", idx);
    end
    n_cmp++;
    if (rp0 !== 10'd11) begin
      n_bad++;
      $display("FAIL bp_rd_ptr: got %0d expected 11", rp0);
    end
    n_cmp++;
    if (fc0 !== 16'd2) begin
      n_bad++;
      $display("FAIL bp_frame_cnt: got %0d expected 2", fc0);
    end
  endtask

  task automatic test_gap;
    logic [35:0] exp;
    logic last;
    int idx, gap;
    idx = 0; gap = 0;
    for (int i = 0; i < 8; i++)
      mem[i] = wd(16'h3333, 9'(i), i == 3 || i == 7, i == 7 ? 2'd3 : 2'd0, i == 7);
    rdy1 = 1'b1;
    c1 = 10'd8;
    #1;
    for (int i = 0; i < 80 && idx < 8; i++) begin
      if (v1) begin
        if (idx == 4) begin
          n_cmp++;
          if (gap !== 12) begin
            n_bad++;
            $display("FAIL gap_length: got %0d expected 12", gap);
          end
          n_cmp++;
          if (rp1 !== 10'd7) begin
            n_bad++;
            $display("FAIL gap_prefetch_rd_ptr: got %0d expected 7", rp1);
          end
        end
        last = idx == 3 || idx == 7;
        exp = wd(16'h3333, 9'(idx), last, idx == 7 ? 2'd3 : 2'd0, idx == 7);
        n_cmp++;
        if ({er1, by1, eop1, d1} !== exp) begin
          n_bad++;
          $display("FAIL gap_word%0d: got %h expected %h", idx, {er1, by1, eop1, d1}, exp);
        end
        idx++;
      end else if (idx == 4) gap++;
      tick;
    end
    n_cmp++;
    if ({idx[3:0], rp1, fc1} !== {4'd8, 10'd8, 16'd2}) begin
      n_bad++;
      $display("FAIL gap_end: got words=%0d rp=%0d fc=%0d expected 8 8 2", idx, rp1, fc1);
    end
  endtask

  task automatic test_mid_reset;
    fill(10'd11, 4, 16'h4444, 1'b1);
    rdy0 = 1'b0;
    c0 = 10'd15;
    #1;
    n_cmp++;
    if (re0 !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_issue: got %b expected 1", re0);
    end
    tick;
    rst = 1'b1; c0 = '0; c1 = '0;
    tick;
    rst = 1'b0;
    rdy0 = 1'b1;
    #1;
    n_cmp++;
    if ({v0, re0, rp0, fc0} !== 28'd0) begin
      n_bad++;
      $display("FAIL mr_ctrl: got v=%b re=%b rp=%0d fc=%0d expected all 0", v0, re0, rp0, fc0);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++;
      if ({v0, er0, by0, eop0, d0} !== 37'd0) begin
        n_bad++;
        $display("FAIL mr_stale%0d: got v=%b %h expected v=0 0", i, v0, {er0, by0, eop0, d0});
      end
    end
  endtask

  task automatic test_wrap;
    fill(10'd0, 508, 16'h5555, 1'b0);
    c0 = 10'd508;
    drain0(508, 10'd0, 16'h5555, 1'b0);
    fill(10'd508, 10, 16'h6666, 1'b1);
    c0 = 10'd518;
    drain0(10, 10'd508, 16'h6666, 1'b1);
    n_cmp++;
    if (rp0 !== 10'd518) begin
      n_bad++;
      $display("FAIL wrap_rd_ptr: got %0d expected 518", rp0);
    end
    n_cmp++;
    if (rp0[9] !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_msb: got %b expected 1", rp0[9]);
    end
    n_cmp++;
    if (fc0 !== 16'd1) begin
      n_bad++;
      $display("FAIL wrap_frame_cnt: got %0d expected 1", fc0);
    end
  endtask

  task automatic test_full_buffer;
    fill(10'd518, 512, 16'h7777, 1'b1);
    c0 = 10'd6;
    drain0(512, 10'd518, 16'h7777, 1'b1);
    n_cmp++;
    if (rp0 !== 10'd6) begin
      n_bad++;
      $display("FAIL full_rd_ptr: got %0d expected 6", rp0);
    end
    tick;
    n_cmp++;
    if ({re0, v0} !== 2'b00) begin
      n_bad++;
      $display("FAIL full_empty: got re=%b v=%b expected 0 0", re0, v0);
    end
    n_cmp++;
    if (fc0 !== 16'd2) begin
      n_bad++;
      $display("FAIL full_frame_cnt: got %0d expected 2", fc0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_frame;
    test_backpressure;
    test_gap;
    test_mid_reset;
    test_wrap;
    test_full_buffer;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
